mem_access_unit: RTL and testbench

- Load/store front end between the core's memory stage and the 2-way data cache.
- Generalises the current read-only alignment wrapper:
  - parametrised 32/64-bit data path;
  - full byte/half/word/(double) load formatting;
  - store lane shifting with byte enables;
  - misalignment faulting;
  - request/response handshake that stalls through cache misses;
  - hit/miss statistics counters.
- The cache sees only naturally aligned, lane-positioned accesses.

---
 rtl/mem_access_unit_if.sv | 43 ++++
 rtl/mem_access_unit.sv | 178 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bundle for mem_access_unit: the core-side request/response handshake, the cache-side
// request bus and the statistics counters. clk and rst_n stay outside the bundle.
//   slave  : view taken by mem_access_unit.
//   master : view taken by the environment (core + cache).
interface mem_access_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  // Core side
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [2:0]              addr_mode;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   write_data;
  logic                    rsp_valid;
  logic                    rsp_fault;
  logic [DATA_WIDTH-1:0]   out;
  // Cache side
  logic                    mem_req;
  logic                    mem_we;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_hit;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  // Statistics
  logic [CNT_WIDTH-1:0]    hit_count;
  logic [CNT_WIDTH-1:0]    miss_count;

  modport slave (
    input  req_valid, req_we, addr_mode, addr, write_data, mem_hit, mem_rdata,
    output req_ready, rsp_valid, rsp_fault, out, mem_req, mem_we, mem_be, mem_addr,
           mem_wdata, hit_count, miss_count
  );

  modport master (
    output req_valid, req_we, addr_mode, addr, write_data, mem_hit, mem_rdata,
    input  req_ready, rsp_valid, rsp_fault, out, mem_req, mem_we, mem_be, mem_addr,
           mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end between the core memory stage and the data cache.
// Accepts one access at a time, checks natural alignment, lane-positions store data and
// byte enables, holds the cache request through miss cycles, formats load data and keeps
// saturating hit/miss counters.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_access_unit_if.slave (core request/response, cache bus, counters)
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,  // 32 or 64
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_access_unit_if.slave      bus
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam bit          Wide     = (DATA_WIDTH == 64);

  typedef enum logic [1:0] {StIdle, StAccess, StMiss, StResp} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            mode_q, mode_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  fault_q, fault_d;
  logic [CNT_WIDTH-1:0]  hit_q, hit_d;
  logic [CNT_WIDTH-1:0]  miss_q, miss_d;

  logic [OffW-1:0]       off_q;
  logic                  mem_req;
  logic [7:0]            be_full;
  logic [NumBytes-1:0]   be_base;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] load_fmt;

  function automatic logic is_legal(logic [2:0] mode, logic we, logic [OffW-1:0] off);
    logic ok;
    case (mode)
      3'b000:  ok = 1'b1;
      3'b001:  ok = !off[0];
      3'b010:  ok = (off[1:0] == 2'b00);
      3'b011:  ok = Wide && (off == '0);
      3'b100:  ok = !we;
      3'b101:  ok = !we && !off[0];
      3'b110:  ok = Wide && !we && (off[1:0] == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(logic [CNT_WIDTH-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

  assign off_q = addr_q[OffW-1:0];

  // Byte-enable pattern before lane shifting; bits above NumBytes are dropped on 32-bit paths.
  always_comb begin
    be_full = 8'h01;
    unique case (mode_q[1:0])
      2'b00: be_full = 8'h01;
      2'b01: be_full = 8'h03;
      2'b10: be_full = 8'h0F;
      2'b11: be_full = 8'hFF;
    endcase
    be_base = be_full[NumBytes-1:0];
  end

  assign lane = bus.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_fmt = lane;
    case (mode_q)
      3'b000:  load_fmt = DATA_WIDTH'($signed(lane[7:0]));
      3'b001:  load_fmt = DATA_WIDTH'($signed(lane[15:0]));
      3'b010:  load_fmt = DATA_WIDTH'($signed(lane[31:0]));
      3'b100:  load_fmt = DATA_WIDTH'(lane[7:0]);
      3'b101:  load_fmt = DATA_WIDTH'(lane[15:0]);
      3'b110:  load_fmt = DATA_WIDTH'(lane[31:0]);
      default: load_fmt = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    out_d   = out_q;
    fault_d = fault_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d  = bus.addr;
          mode_d  = bus.addr_mode;
          we_d    = bus.req_we;
          wdata_d = bus.write_data;
          if (is_legal(bus.addr_mode, bus.req_we, bus.addr[OffW-1:0])) begin
            fault_d = 1'b0;
            state_d = StAccess;
          end else begin
            // Faults skip the cache entirely and respond next cycle.
            fault_d = 1'b1;
            out_d   = '0;
            state_d = StResp;
          end
        end
      end
      StAccess: begin
        if (bus.mem_hit) begin
          out_d   = we_q ? '0 : load_fmt;
          hit_d   = sat_inc(hit_q);
          state_d = StResp;
        end else begin
          miss_d  = sat_inc(miss_q);
          state_d = StMiss;
        end
      end
      StMiss: begin
        if (bus.mem_hit) begin
          out_d   = we_q ? '0 : load_fmt;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      mode_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      out_q   <= '0;
      fault_q <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      out_q   <= out_d;
      fault_q <= fault_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Cache bus is decoded straight from the state register so reset drops it at once.
  assign mem_req        = (state_q == StAccess) || (state_q == StMiss);
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_req & we_q;
  assign bus.mem_be     = mem_req ? (be_base << off_q) : '0;
  assign bus.mem_addr   = {addr_q[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
  assign bus.mem_wdata  = mem_req ? (wdata_q << {off_q, 3'b000}) : '0;

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_fault  = (state_q == StResp) & fault_q;
  assign bus.out        = out_q;
  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit path with wide counters; 64-bit path with 2-bit counters to reach saturation.
  mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) if32 ();
  mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .CNT_WIDTH(2))  if64 ();

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if32.slave)
  );

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .CNT_WIDTH(2)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if64.slave)
  );

  // Shared stimulus, steered to one DUT by sel64.
  logic        sel64 = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  addr_mode = 3'b000;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        mem_hit = 1'b0;
  logic [63:0] mem_rdata = '0;

  assign if32.req_valid  = req_valid & ~sel64;
  assign if32.req_we     = req_we;
  assign if32.addr_mode  = addr_mode;
  assign if32.addr       = addr;
  assign if32.write_data = wdata[31:0];
  assign if32.mem_hit    = mem_hit & ~sel64;
  assign if32.mem_rdata  = mem_rdata[31:0];
  assign if64.req_valid  = req_valid & sel64;
  assign if64.req_we     = req_we;
  assign if64.addr_mode  = addr_mode;
  assign if64.addr       = addr;
  assign if64.write_data = wdata;
  assign if64.mem_hit    = mem_hit & sel64;
  assign if64.mem_rdata  = mem_rdata;

  logic        o_ready, o_rsp, o_fault, o_req, o_we;
  logic [7:0]  o_be;
  logic [31:0] o_maddr;
  logic [63:0] o_wdata, o_out;
  logic [15:0] o_hits, o_misses;

  assign o_ready  = sel64 ? if64.req_ready : if32.req_ready;
  assign o_rsp    = sel64 ? if64.rsp_valid : if32.rsp_valid;
  assign o_fault  = sel64 ? if64.rsp_fault : if32.rsp_fault;
  assign o_req    = sel64 ? if64.mem_req   : if32.mem_req;
  assign o_we     = sel64 ? if64.mem_we    : if32.mem_we;
  assign o_be     = sel64 ? if64.mem_be    : {4'h0, if32.mem_be};
  assign o_maddr  = sel64 ? if64.mem_addr  : if32.mem_addr;
  assign o_wdata  = sel64 ? if64.mem_wdata : {32'h0, if32.mem_wdata};
  assign o_out    = sel64 ? if64.out       : {32'h0, if32.out};
  assign o_hits   = sel64 ? {14'h0, if64.hit_count}  : if32.hit_count;
  assign o_misses = sel64 ? {14'h0, if64.miss_count} : if32.miss_count;

  int tests = 0;
  int fails = 0;
  int exp_hit32 = 0, exp_miss32 = 0, exp_hit64 = 0, exp_miss64 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          wide;
    bit          we;
    logic [2:0]  mode;
    logic [31:0] a;
    logic [63:0] wd;
    logic [63:0] rd;
    int          misses;
    bit          fault;
    logic [63:0] out;
    logic [7:0]  be;
    logic [63:0] mwd;
  } vec_t;

  function automatic vec_t mk(bit wide, bit we, logic [2:0] mode, logic [31:0] a,
                              logic [63:0] wd, logic [63:0] rd, int misses, bit fault,
                              logic [63:0] out, logic [7:0] be, logic [63:0] mwd);
    vec_t v;
    v.wide = wide; v.we = we; v.mode = mode; v.a = a; v.wd = wd; v.rd = rd;
    v.misses = misses; v.fault = fault; v.out = out; v.be = be; v.mwd = mwd;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int          lat = 0;
    int          reqs = 0;
    bit          done = 1'b0;
    logic        flt = 1'b0;
    logic [63:0] res = '0;
    logic [31:0] exp_maddr;
    exp_maddr = v.wide ? (v.a & ~32'h7) : (v.a & ~32'h3);
    sel64 = v.wide;
    #0;
    check($sformatf("v%0d ready", idx), 64'(o_ready), 64'd1);
    req_valid = 1'b1; req_we = v.we; addr_mode = v.mode; addr = v.a; wdata = v.wd;
    mem_hit = 1'b0; mem_rdata = v.rd;
    @(posedge clk); #1;
    // Scramble request inputs to prove they were captured at accept.
    req_valid = 1'b0; req_we = ~v.we; addr_mode = 3'b111; addr = 32'hFFFF_FFFF; wdata = '1;
    for (int c = 1; c <= 20 && !done; c++) begin
      mem_hit = (c > v.misses);
      @(negedge clk);
      if (o_req) begin
        reqs++;
        check($sformatf("v%0d mem_addr", idx), 64'(o_maddr), 64'(exp_maddr));
        check($sformatf("v%0d mem_be", idx), 64'(o_be), 64'(v.be));
        check($sformatf("v%0d mem_wdata", idx), o_wdata, v.mwd);
        check($sformatf("v%0d mem_we", idx), 64'(o_we), 64'(v.we));
      end
      if (o_rsp) begin
        lat = c; done = 1'b1; flt = o_fault; res = o_out;
      end
      @(posedge clk); #1;
    end
    mem_hit = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL v%0d timeout: no rsp_valid within 20 cycles", idx);
    end else begin
      check($sformatf("v%0d latency", idx), 64'(lat), v.fault ? 64'd1 : 64'(2 + v.misses));
      check($sformatf("v%0d req_cycles", idx), 64'(reqs), v.fault ? 64'd0 : 64'(1 + v.misses));
      check($sformatf("v%0d fault", idx), 64'(flt), 64'(v.fault));
      check($sformatf("v%0d out", idx), res, v.out);
    end
    if (!v.fault) begin
      if (v.wide) begin
        if (v.misses > 0) exp_miss64 = (exp_miss64 < 3) ? exp_miss64 + 1 : 3;
        else              exp_hit64  = (exp_hit64 < 3) ? exp_hit64 + 1 : 3;
      end else begin
        if (v.misses > 0) exp_miss32 = (exp_miss32 < 65535) ? exp_miss32 + 1 : 65535;
        else              exp_hit32  = (exp_hit32 < 65535) ? exp_hit32 + 1 : 65535;
      end
    end
    @(negedge clk);
    check($sformatf("v%0d rsp_one_cycle", idx), 64'(o_rsp), 64'd0);
    check($sformatf("v%0d out_held", idx), o_out, v.out);
    check($sformatf("v%0d hit_count", idx), 64'(o_hits),
          v.wide ? 64'(exp_hit64) : 64'(exp_hit32));
    check($sformatf("v%0d miss_count", idx), 64'(o_misses),
          v.wide ? 64'(exp_miss64) : 64'(exp_miss32));
    @(posedge clk); #1;
  endtask

  vec_t vecs[$];

  initial begin
    //           wide we  mode    addr          wdata                  rdata                  miss flt out                    be     mem_wdata
    vecs.push_back(mk(0, 0, 3'b000, 32'h1003, 64'h0, 64'h80FF_0000, 0, 0, 64'hFFFF_FF80, 8'h08, 64'h0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h2002, 64'h0000_BEEF, 64'h0, 0, 0, 64'h0, 8'h0C, 64'hBEEF_0000));
    vecs.push_back(mk(0, 0, 3'b010, 32'h3000, 64'h0, 64'h1234_5678, 3, 0, 64'h1234_5678, 8'h0F, 64'h0));
    vecs.push_back(mk(0, 0, 3'b001, 32'h0001, 64'h0, 64'h0, 0, 1, 64'h0, 8'h00, 64'h0));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0006, 64'h1111_2222, 64'h0, 0, 1, 64'h0, 8'h00, 64'h0));
    vecs.push_back(mk(0, 0, 3'b100, 32'h1001, 64'h0, 64'h0000_9A00, 0, 0, 64'h9A, 8'h02, 64'h0));
    vecs.push_back(mk(0, 0, 3'b101, 32'h0002, 64'h0, 64'hF00D_0000, 0, 0, 64'hF00D, 8'h0C, 64'h0));
    vecs.push_back(mk(0, 0, 3'b001, 32'h0002, 64'h0, 64'hF00D_1234, 0, 0, 64'hFFFF_F00D, 8'h0C, 64'h0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h0005, 64'h0000_00AB, 64'h0, 0, 0, 64'h0, 8'h02, 64'h0000_AB00));
    vecs.push_back(mk(0, 0, 3'b110, 32'h4004, 64'h0, 64'h0, 0, 1, 64'h0, 8'h00, 64'h0));
    vecs.push_back(mk(0, 0, 3'b111, 32'h0000, 64'h0, 64'h0, 0, 1, 64'h0, 8'h00, 64'h0));
    vecs.push_back(mk(0, 0, 3'b011, 32'h0000, 64'h0, 64'h0, 0, 1, 64'h0, 8'h00, 64'h0));
    vecs.push_back(mk(0, 1, 3'b100, 32'h0000, 64'h0, 64'h0, 0, 1, 64'h0, 8'h00, 64'h0));
    vecs.push_back(mk(0, 0, 3'b010, 32'h3000, 64'h0, 64'hCAFE_BABE, 1, 0, 64'hCAFE_BABE, 8'h0F, 64'h0));
    vecs.push_back(mk(1, 0, 3'b110, 32'h4004, 64'h0, 64'h8000_0001_DEAD_BEEF, 0, 0,
                      64'h0000_0000_8000_0001, 8'hF0, 64'h0));
    vecs.push_back(mk(1, 0, 3'b011, 32'h0008, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0,
                      64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h4004, 64'h0, 64'h8000_0001_DEAD_BEEF, 0, 0,
                      64'hFFFF_FFFF_8000_0001, 8'hF0, 64'h0));
    vecs.push_back(mk(1, 1, 3'b011, 32'h0010, 64'h1122_3344_5566_7788, 64'h0, 0, 0, 64'h0,
                      8'hFF, 64'h1122_3344_5566_7788));
    vecs.push_back(mk(1, 0, 3'b011, 32'h0004, 64'h0, 64'h0, 0, 1, 64'h0, 8'h00, 64'h0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h0004, 64'hAABB_CCDD, 64'h0, 0, 0, 64'h0, 8'hF0,
                      64'hAABB_CCDD_0000_0000));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0007, 64'h0, 64'h7F00_0000_0000_0000, 0, 0, 64'h7F,
                      8'h80, 64'h0));
    vecs.push_back(mk(1, 0, 3'b101, 32'h0006, 64'h0, 64'h8001_0000_0000_0000, 2, 0, 64'h8001,
                      8'hC0, 64'h0));

    // Reset values while held in reset.
    #3;
    for (int s = 0; s < 2; s++) begin
      sel64 = s[0];
      #1;
      check("rst ready", 64'(o_ready), 64'd1);
      check("rst rsp_valid", 64'(o_rsp), 64'd0);
      check("rst fault", 64'(o_fault), 64'd0);
      check("rst mem_req", 64'(o_req), 64'd0);
      check("rst mem_we", 64'(o_we), 64'd0);
      check("rst mem_be", 64'(o_be), 64'd0);
      check("rst out", o_out, 64'd0);
      check("rst counts", {o_hits, o_misses}, 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset in the middle of a miss: request drops without a clock edge, no response follows.
    sel64 = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; addr_mode = 3'b010; addr = 32'h3000; mem_hit = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid-miss mem_req", 64'(o_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async drop mem_req", 64'(o_req), 64'd0);
    check("async ready", 64'(o_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_hit = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post-reset no rsp", 64'(o_rsp), 64'd0);
    end
    mem_hit = 1'b0;
    check("post-reset ready", 64'(o_ready), 64'd1);
    check("post-reset counts32", {o_hits, o_misses}, 64'd0);
    sel64 = 1'b1;
    #1;
    check("post-reset counts64", {o_hits, o_misses}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
